mips_load_store_unit: RTL and testbench
=======================================

# mips_load_store_unit

Data-side memory initiator between the CPU execute stage and the Harvard data port (byteenable, data_address, data_read, data_write, data_writedata, data_readdata). Accepts one load or store request at a time over a valid/ready handshake. Drives a single word-aligned memory access with the correct byte lanes. Returns a one-cycle response carrying the sign- or zero-extended load data or a misalignment error.

## Interface
- READ_LATENCY, 1, number of cycles after the data_read edge until data_readdata is valid; legal range 1–15
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  4  op[3]=store, op[2]=unsigned, op[1:0]=size (00 byte, 01 half, 10 word, 11 reserved)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  misaligned or reserved-size request; qualified by resp_valid
- resp_rdata  out  32  extended load data; 0 for store and error responses
- data_address  out  32  {addr[31:2],2'b00}
- byteenable  out  4  lane enables; bit n covers bits [8n+7:8n]
- data_read  out  1  read strobe
- data_write  out  1  write strobe
- data_writedata  out  32  lane-replicated store data
- data_readdata  in  32  read data from memory

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch op, addr and wdata.
  - Error request → RESP with err=1, no memory access.
  - Otherwise → ISSUE.
- Error: size=11, half with addr[0]=1, or word with addr[1:0]≠0.
- ISSUE, exactly one cycle: data_read or data_write =1, never both; address and byteenable valid.
  - Store → RESP.
  - Load → WAIT, counter loaded with READ_LATENCY.
- WAIT: counter decrements each cycle. At the edge ending the cycle where it reads 1, capture the extended data_readdata → RESP.
- RESP, one cycle: resp_valid=1 → IDLE.
- Lane mapping is little-endian; lane = addr[1:0].
  - Byte: be = 1<<addr[1:0]; writedata = {4{wdata[7:0]}}; load data = readdata lane addr[1:0].
  - Half: be = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}; load data = readdata half addr[1].
  - Word: be = 1111; writedata = wdata; load data = readdata.
- Extension: sign-extend when op[2]=0, zero-extend when op[2]=1. op[2] is ignored for words and stores.
- Outside ISSUE, all memory-side outputs are 0.
- No pipelining: req_valid outside IDLE is ignored and never latched.

## Timing
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. All other outputs are 0. FSM returns to IDLE.
- Latency, with the request accepted at edge a (end of the IDLE cycle):
  - ISSUE is cycle a+1.
  - Load response in cycle a+2+READ_LATENCY; a+3 for the default.
  - Store response in cycle a+2.
  - Error response in cycle a+1.
- Next acceptance is possible in the cycle after RESP, so back-to-back loads have a 4-cycle period at the default latency.
- Reset mid-operation (any state): next cycle is IDLE, all outputs are 0, and no response is ever issued for the aborted request. A store in ISSUE when reset asserts still strobes that cycle, because reset is synchronous.
- resp_rdata and resp_err are registered and stable throughout the RESP cycle. They return to 0 afterwards.

## Structure
- Shared package mips_lsu_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the op bit-position constants
  - the state enum lsu_state_t
- Sub-module mips_lsu_align, purely combinational, computes from op, addr[1:0] and wdata:
  - byteenable
  - replicated writedata
  - the misalignment flag
  - extraction and extension of readdata
- The top level holds the FSM, request latch, latency counter and response registers.

## Test plan
- SW 0xDEADBEEF to 0xBFC00010, then LW at the same address, against the dummy RAM at default latency:
  - ISSUE of the SW shows be=1111.
  - LW response in cycle a+3 with rdata=0xDEADBEEF, err=0.
- SB 0x80 to 0xBFC00013, then LB from 0xBFC00013:
  - SB shows be=1000, writedata=0x80808080.
  - LB returns 0xFFFFFF80.
  - LBU at the same address returns 0x00000080.
- SH 0x8001 to 0xBFC00022:
  - be=1100.
  - LH returns 0xFFFF8001; LHU returns 0x00008001.
  - Lower half of the word is unchanged.
- LW at 0xBFC00001, SH at 0xBFC00003, and size=11:
  - Each gives resp_err=1 in cycle a+1.
  - data_read and data_write stay 0.
- Reset asserted during WAIT of an LW:
  - No resp_valid follows.
  - req_ready=1 in the cycle after reset deasserts.
  - A new LW then completes normally.
- READ_LATENCY=3 build, with the RAM read-data delay matched to 3: LW response in cycle a+5 with correct data.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS data-side load/store unit.
// Holds the request op field layout, the access-size encodings and the
// controller state type used by mips_load_store_unit and mips_lsu_align.
package mips_lsu_pkg;

  // req_op bit positions: op[3]=store, op[2]=unsigned, op[1:0]=size
  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/mips_lsu_align.sv
// Byte-lane steering for the load/store unit. Purely combinational.
// Ports:
//   op        in  4   request op (store, unsigned, size)
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  right-justified store data
//   rdata     in  32  raw word from the data port
//   be        out 4   little-endian lane enables
//   wdata_rep out 32  store data replicated across the enabled lanes
//   misalign  out 1   reserved size or unaligned half/word
//   rdata_ext out 32  selected lane(s), sign- or zero-extended
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  assign byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign is_unsigned = op[OP_UNSIGNED];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    misalign  = 1'b0;
    rdata_ext = 32'h0;
    case (op[1:0])
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
        rdata_ext = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = |addr_lo;
        rdata_ext = rdata;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Data-side memory initiator between the execute stage and the data port.
// Takes one load/store at a time, performs a single word-aligned access with
// the right byte lanes, and returns a one-cycle response.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_op, req_addr, req_wdata     request op, byte address, store data
//   resp_valid, resp_err, resp_rdata  one-cycle response, extended load data
//   data_address, byteenable, data_read, data_write, data_writedata,
//   data_readdata                   data port, driven only during ISSUE
//
// state | meaning
// IDLE  | ready for a request; latch it on req_valid
// ISSUE | one-cycle memory strobe
// WAIT  | counting down read latency
// RESP  | response pulse
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] data_address,
  output logic [3:0]  byteenable,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY);

  lsu_state_t  state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [3:0]  al_op;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata_rep;
  logic        al_misalign;
  logic [31:0] al_rdata_ext;
  logic        in_idle;
  logic        read_done;

  assign in_idle   = (state_q == ST_IDLE);
  assign read_done = (state_q == ST_WAIT) && (cnt_q == 4'd1);

  // In IDLE the aligner looks at the incoming request so the error can be
  // decided at acceptance; afterwards it works from the latched request.
  assign al_op      = in_idle ? req_op : op_q;
  assign al_addr_lo = in_idle ? req_addr[1:0] : addr_q[1:0];

  mips_lsu_align u_align (
    .op        (al_op),
    .addr_lo   (al_addr_lo),
    .wdata     (wdata_q),
    .rdata     (data_readdata),
    .be        (al_be),
    .wdata_rep (al_wdata_rep),
    .misalign  (al_misalign),
    .rdata_ext (al_rdata_ext)
  );

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    data_address   = 32'h0;
    byteenable     = 4'b0000;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = 32'h0;
    case (state_q)
      ST_IDLE: begin
        req_ready = ~reset;
        if (req_valid) state_d = al_misalign ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        data_address   = {addr_q[31:2], 2'b00};
        byteenable     = al_be;
        data_read      = ~op_q[OP_STORE];
        data_write     = op_q[OP_STORE];
        data_writedata = al_wdata_rep;
        state_d        = op_q[OP_STORE] ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (read_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'h0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      cnt_q        <= 4'h0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (in_idle && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_ISSUE)     cnt_q <= LAT_INIT;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q - 4'd1;
      // Response registers hold a value only for the RESP cycle.
      resp_err_q   <= in_idle && req_valid && al_misalign;
      resp_rdata_q <= read_done ? al_rdata_ext : 32'h0;
    end
  end

  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_init = 1'b1;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  // index 0: default latency unit, index 1: READ_LATENCY=3 unit
  logic        req_v [2];
  logic        rdy   [2];
  logic        rv    [2];
  logic        re    [2];
  logic [31:0] rr    [2];
  logic [31:0] da    [2];
  logic [3:0]  be    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wd    [2];
  logic [31:0] rdat  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_v[0]), .req_ready(rdy[0]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_err(re[0]), .resp_rdata(rr[0]),
    .data_address(da[0]), .byteenable(be[0]), .data_read(rd[0]),
    .data_write(wr[0]), .data_writedata(wd[0]), .data_readdata(rdat[0])
  );

  mips_load_store_unit #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_v[1]), .req_ready(rdy[1]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_err(re[1]), .resp_rdata(rr[1]),
    .data_address(da[1]), .byteenable(be[1]), .data_read(rd[1]),
    .data_write(wr[1]), .data_writedata(wd[1]), .data_readdata(rdat[1])
  );

  // Dummy RAM per unit: byte-enabled writes, read data delayed LAT edges.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [3];
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8] <= 32'h12345678;
      end else if (wr[g]) begin
        for (int b = 0; b < 4; b++)
          if (be[g][b]) mem[da[g][9:2]][8*b +: 8] <= wd[g][8*b +: 8];
      end
      pipe[0] <= rd[g] ? mem[da[g][9:2]] : 32'h0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rdat[g] = pipe[LAT-1];
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its response; n counts cycles after
  // the accepting edge, so n==1 is cycle a+1.
  task automatic run_req(input int sel, input string tag, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err,
                         input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd);
    int n;
    logic got;
    n = 0;
    @(negedge clk);
    while (!rdy[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_val({tag, "_ready"}, {31'h0, rdy[sel]}, 32'h1);
    req_v[sel] = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_v[sel] = 1'b0;
    got = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (exp_err) begin
          chk_val({tag, "_rd"}, {31'h0, rd[sel]}, 32'h0);
          chk_val({tag, "_wr"}, {31'h0, wr[sel]}, 32'h0);
        end else begin
          chk_val({tag, "_rd"}, {31'h0, rd[sel]}, {31'h0, ~op[3]});
          chk_val({tag, "_wr"}, {31'h0, wr[sel]}, {31'h0, op[3]});
          chk_val({tag, "_be"}, {28'h0, be[sel]}, {28'h0, exp_be});
          chk_val({tag, "_addr"}, da[sel], {addr[31:2], 2'b00});
          if (op[3]) chk_val({tag, "_wd"}, wd[sel], exp_wd);
        end
      end
      if (rv[sel]) begin
        got = 1'b1;
        chk_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk_val({tag, "_err"}, {31'h0, re[sel]}, {31'h0, exp_err});
        chk_val({tag, "_rdata"}, rr[sel], exp_rdata);
        break;
      end
    end
    chk_val({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
    @(negedge clk);
    chk_val({tag, "_pulse_end"}, {31'h0, rv[sel]}, 32'h0);
    chk_val({tag, "_rdata_clr"}, rr[sel], 32'h0);
  endtask

  initial begin
    int cnt;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_val("rst_ready", {31'h0, rdy[0]}, 32'h0);
    chk_val("rst_resp_valid", {31'h0, rv[0]}, 32'h0);
    chk_val("rst_strobes", {30'h0, rd[0], wr[0]}, 32'h0);
    chk_val("rst_be", {28'h0, be[0]}, 32'h0);
    chk_val("rst_rdata", rr[0], 32'h0);
    ram_init = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_val("rst_ready_after", {31'h0, rdy[0]}, 32'h1);

    //      sel tag     op       addr          wdata        lat err rdata         be       wd
    run_req(0, "sw",   4'b1010, 32'hBFC00010, 32'hDEADBEEF, 2, 0, 32'h0,        4'b1111, 32'hDEADBEEF);
    run_req(0, "lw",   4'b0010, 32'hBFC00010, 32'h0,        3, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
    run_req(0, "lb0",  4'b0000, 32'hBFC00010, 32'h0,        3, 0, 32'hFFFFFFEF, 4'b0001, 32'h0);
    run_req(0, "lbu2", 4'b0100, 32'hBFC00012, 32'h0,        3, 0, 32'h000000AD, 4'b0100, 32'h0);
    run_req(0, "sb",   4'b1000, 32'hBFC00013, 32'h00000080, 2, 0, 32'h0,        4'b1000, 32'h80808080);
    run_req(0, "lb",   4'b0000, 32'hBFC00013, 32'h0,        3, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    run_req(0, "lbu",  4'b0100, 32'hBFC00013, 32'h0,        3, 0, 32'h00000080, 4'b1000, 32'h0);
    run_req(0, "sh",   4'b1001, 32'hBFC00022, 32'h00008001, 2, 0, 32'h0,        4'b1100, 32'h80018001);
    run_req(0, "lh",   4'b0001, 32'hBFC00022, 32'h0,        3, 0, 32'hFFFF8001, 4'b1100, 32'h0);
    run_req(0, "lhu",  4'b0101, 32'hBFC00022, 32'h0,        3, 0, 32'h00008001, 4'b1100, 32'h0);
    run_req(0, "lhu_lo", 4'b0101, 32'hBFC00020, 32'h0,      3, 0, 32'h00005678, 4'b0011, 32'h0);
    run_req(0, "err_lw", 4'b0010, 32'hBFC00001, 32'h0,      1, 1, 32'h0,        4'b0000, 32'h0);
    run_req(0, "err_sh", 4'b1001, 32'hBFC00003, 32'h1234,   1, 1, 32'h0,        4'b0000, 32'h0);
    run_req(0, "err_sz", 4'b0011, 32'hBFC00010, 32'h0,      1, 1, 32'h0,        4'b0000, 32'h0);

    // Reset while an LW sits in WAIT.
    @(negedge clk);
    req_v[0] = 1'b1;
    req_op = 4'b0010;
    req_addr = 32'hBFC00010;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    @(negedge clk);
    chk_val("rw_issue_rd", {31'h0, rd[0]}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_val("rw_no_resp", {31'h0, rv[0]}, 32'h0);
    chk_val("rw_mem_idle", {30'h0, rd[0], wr[0]}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk_val("rw_ready", {31'h0, rdy[0]}, 32'h1);
    cnt = 0;
    repeat (5) begin
      if (rv[0]) cnt++;
      @(negedge clk);
    end
    chk_val("rw_no_late_resp", 32'(cnt), 32'h0);
    run_req(0, "rw_lw", 4'b0010, 32'hBFC00010, 32'h0, 3, 0, 32'h80ADBEEF, 4'b1111, 32'h0);

    // READ_LATENCY=3 unit.
    run_req(1, "l3_sw", 4'b1010, 32'hBFC00030, 32'hCAFEF00D, 2, 0, 32'h0,        4'b1111, 32'hCAFEF00D);
    run_req(1, "l3_lw", 4'b0010, 32'hBFC00030, 32'h0,        5, 0, 32'hCAFEF00D, 4'b1111, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
